// File: rtl/clk_div_pwm_pkg.sv
// ============================================================================
// Module  : clk_div_pwm_pkg
// Brief   : Shared state encoding and limits for the clock divider / PWM.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_div_pwm_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Shortest period that still yields a distinguishable high and low phase.
    localparam int unsigned MIN_PERIOD = 2;

endpackage

`default_nettype wire

// File: rtl/clk_div_pwm.sv
// ============================================================================
// Module  : clk_div_pwm
// Brief   : Programmable clock divider / PWM generator.
//           Configuration changes are double-buffered and take effect only
//           at a period boundary.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_pwm
    import clk_div_pwm_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEF_PERIOD = 10,
    parameter int unsigned DEF_HIGH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_period,
    input  logic [WIDTH-1:0] cfg_high,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_tick,
    output logic [WIDTH-1:0] cnt
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] per_act_q, per_act_d;
    logic [WIDTH-1:0] high_act_q, high_act_d;
    logic [WIDTH-1:0] pend_per_q, pend_per_d;
    logic [WIDTH-1:0] pend_high_q, pend_high_d;
    logic             pend_vld_q, pend_vld_d;

    logic             w_accept;
    logic             w_last;
    logic             w_bound;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        per_act_d   = per_act_q;
        high_act_d  = high_act_q;
        pend_per_d  = pend_per_q;
        pend_high_d = pend_high_q;
        pend_vld_d  = pend_vld_q;
        err_d       = 1'b0;

        w_accept = cfg_valid && !pend_vld_q;
        w_last   = (cnt_q == per_act_q - WIDTH'(1));
        w_bound  = en && ((state_q == ST_IDLE) || w_last);

        // Apply uses the slot as it was before this edge; an offer accepted on
        // the same edge can only land when the slot was empty, so it waits.
        if (w_bound && pend_vld_q) begin
            per_act_d  = pend_per_q;
            high_act_d = pend_high_q;
            pend_vld_d = 1'b0;
        end

        if (w_accept) begin
            if (cfg_period < WIDTH'(MIN_PERIOD)) begin
                err_d = 1'b1;
            end else begin
                pend_per_d  = cfg_period;
                pend_high_d = cfg_high;
                pend_vld_d  = 1'b1;
            end
        end

        if (en) begin
            state_d = ST_RUN;
            cnt_d   = ((state_q == ST_RUN) && !w_last) ? cnt_q + WIDTH'(1) : '0;
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end

        // Outputs are derived from next-cycle values so they stay aligned with cnt.
        clk_out_d = en && (cnt_d < high_act_d);
        tick_d    = en && (cnt_d == per_act_d - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            err_q       <= 1'b0;
            per_act_q   <= WIDTH'(DEF_PERIOD);
            high_act_q  <= WIDTH'(DEF_HIGH);
            pend_per_q  <= '0;
            pend_high_q <= '0;
            pend_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            err_q       <= err_d;
            per_act_q   <= per_act_d;
            high_act_q  <= high_act_d;
            pend_per_q  <= pend_per_d;
            pend_high_q <= pend_high_d;
            pend_vld_q  <= pend_vld_d;
        end
    end

    assign cfg_ready   = !pend_vld_q;
    assign cfg_err     = err_q;
    assign clk_out     = clk_out_q;
    assign period_tick = tick_q;
    assign cnt         = cnt_q;

endmodule

`default_nettype wire

// File: doc/clk_div_pwm.md
CLK_DIV_PWM -- requirements
Module: clk_div_pwm

Interface
REQ-001 Parameter WIDTH, default 16, width of the period/high-time counters and config fields.
REQ-002 Parameter DEF_PERIOD, default 10, period in clk cycles after reset.
REQ-003 Parameter DEF_HIGH, default 5, high time in clk cycles after reset.
REQ-004 clk  input  1  single clock, all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 en  input  1  run enable; 1 = generate waveform, 0 = idle.
REQ-007 cfg_valid  input  1  new configuration offered.
REQ-008 cfg_period  input  WIDTH  requested period in clk cycles.
REQ-009 cfg_high  input  WIDTH  requested high time in clk cycles.
REQ-010 cfg_ready  output  1  block can accept a configuration.
REQ-011 cfg_err  output  1  one-cycle pulse: offered configuration rejected.
REQ-012 clk_out  output  1  generated divided clock / PWM waveform, registered.
REQ-013 period_tick  output  1  one-cycle pulse on the last cycle of each period.
REQ-014 cnt  output  WIDTH  current position within the period, 0..period_act-1.

Function
REQ-015 Two states: IDLE and RUN; IDLE -> RUN when en=1, RUN -> IDLE when en=0, both on the next edge.
REQ-016 In IDLE: cnt=0, clk_out=0, period_tick=0.
REQ-017 Active config registers (period_act, high_act) and one pending slot (pend_period, pend_high, pend_vld).
REQ-018 Handshake: config accepted on an edge where cfg_valid=1 and cfg_ready=1; cfg_ready = !pend_vld.
REQ-019 Accepted config with cfg_period < 2 is rejected: cfg_err=1 the next cycle, pending slot unchanged.
REQ-020 Valid accepted config is stored in the pending slot, pend_vld set.
REQ-021 Pending config is copied to the active registers, and pend_vld is cleared, on the IDLE->RUN edge or on the edge where cnt wraps from period_act-1 to 0; never mid-period.
REQ-022 Acceptance and a wrap on the same edge: the new config is stored as pending and is applied at the following wrap, not the current one.
REQ-023 In RUN, cnt increments by 1 per cycle and wraps to 0 after period_act-1; first RUN cycle has cnt=0.
REQ-024 clk_out=1 exactly in cycles where cnt < high_act, aligned with cnt (same edge updates both).
REQ-025 high_act=0 gives clk_out constantly 0; high_act >= period_act gives clk_out constantly 1 in RUN.
REQ-026 period_tick=1 exactly in RUN cycles where cnt = period_act-1.
REQ-027 en dropped mid-period: next edge enters IDLE, cnt=0, clk_out=0; pending config retained.
REQ-028 Comparisons are unsigned on WIDTH bits; no arithmetic overflow, since cnt never exceeds period_act-1.

Reset
REQ-029 On rst=1 at an edge: state=IDLE, cnt=0, clk_out=0, period_tick=0, cfg_err=0, pend_vld=0, cfg_ready=1, period_act=DEF_PERIOD, high_act=DEF_HIGH.
REQ-030 rst has priority over en and cfg_valid; reset mid-period discards any pending config.

Structure
REQ-031 State encoding (IDLE, RUN) and the minimum legal period constant (2) live in the shared package.
REQ-032 Single module, no sub-modules; counter, config slot and FSM in one file.

Verification
REQ-033 Reset, en=1, default config -> clk_out high for cnt 0..4 and low for cnt 5..9, period_tick every 10th cycle.
REQ-034 Mid-period offer period=4, high=1 -> current 10-cycle period completes unchanged, then a 1-high/3-low pattern; cfg_ready low until applied.
REQ-035 Offer period=1 -> cfg_err pulses one cycle, waveform unchanged, cfg_ready stays 1.
REQ-036 period=6, high=0 then period=6, high=9 -> clk_out constant 0, then constant 1, each starting at a wrap boundary.
REQ-037 Offer timed on the wrap cycle (cnt=period_act-1) -> applied at the next wrap, one full old period later.
REQ-038 en=0 at cnt=3, then en=1 -> IDLE with clk_out=0, then restart at cnt=0 with pending config applied; rst at cnt=7 -> all outputs at reset values next cycle.
